// File: rtl/axi4_to_wb_bridge.sv
// AXI4 slave to Wishbone classic master bridge.
// Handles one transaction at a time and issues one Wishbone transfer per AXI beat.
module axi4_to_wb_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    axi_awvalid_i,
    output logic                    axi_awready_o,
    input  logic [ADDR_WIDTH-1:0]   axi_awaddr_i,
    input  logic [ID_WIDTH-1:0]     axi_awid_i,
    input  logic [7:0]              axi_awlen_i,
    input  logic [1:0]              axi_awburst_i,
    input  logic                    axi_wvalid_i,
    output logic                    axi_wready_o,
    input  logic [DATA_WIDTH-1:0]   axi_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] axi_wstrb_i,
    input  logic                    axi_wlast_i,
    output logic                    axi_bvalid_o,
    input  logic                    axi_bready_i,
    output logic [1:0]              axi_bresp_o,
    output logic [ID_WIDTH-1:0]     axi_bid_o,
    input  logic                    axi_arvalid_i,
    output logic                    axi_arready_o,
    input  logic [ADDR_WIDTH-1:0]   axi_araddr_i,
    input  logic [ID_WIDTH-1:0]     axi_arid_i,
    input  logic [7:0]              axi_arlen_i,
    input  logic [1:0]              axi_arburst_i,
    output logic                    axi_rvalid_o,
    input  logic                    axi_rready_i,
    output logic [DATA_WIDTH-1:0]   axi_rdata_o,
    output logic [1:0]              axi_rresp_o,
    output logic [ID_WIDTH-1:0]     axi_rid_o,
    output logic                    axi_rlast_o,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    output logic [DATA_WIDTH/8-1:0] wb_wstrb_o,
    output logic [ADDR_WIDTH-1:0]   wb_addr_o,
    output logic [DATA_WIDTH-1:0]   wb_data_o,
    input  logic [DATA_WIDTH-1:0]   wb_data_i,
    input  logic                    wb_ack_i
);

    // state   | meaning
    // IDLE    | arbitrate AR/AW, capture the winning address phase
    // RD_BUS  | Wishbone read beat in progress
    // RD_RESP | presenting one R beat
    // WR_DATA | waiting for the next W beat
    // WR_BUS  | Wishbone write beat in progress
    // WR_RESP | presenting the B response
    typedef enum logic [2:0] {IDLE, RD_BUS, RD_RESP, WR_DATA, WR_BUS, WR_RESP} state_t;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TO_VAL = TW'(TIMEOUT);

    state_t                  state_q, state_d;
    logic                    run_q;
    logic                    last_rd_q;
    logic [ID_WIDTH-1:0]     id_q;
    logic [7:0]              len_q;
    logic [7:0]              beat_q;
    logic [1:0]              burst_q;
    logic                    err_q;
    logic [TW-1:0]           tcnt_q;
    logic [ADDR_WIDTH-1:0]   wb_addr_q;
    logic [DATA_WIDTH-1:0]   wb_data_q;
    logic [DATA_WIDTH/8-1:0] wb_wstrb_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [1:0]              rresp_q;

    logic                    grant_rd, grant_wr;
    logic                    bus_state, tmo, bus_done, is_last;
    logic [ADDR_WIDTH-1:0]   addr_nxt;

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                        input logic [7:0] len,
                                                        input logic [1:0] burst);
        logic [ADDR_WIDTH-1:0] inc;
        logic [ADDR_WIDTH-1:0] mask;
        inc  = a + ADDR_WIDTH'(4);
        // wrap boundary is (len+1)*4 bytes, i.e. the mask {len, 2'b11}
        mask = ADDR_WIDTH'({len, 2'b11});
        case (burst)
            2'b00:   next_addr = a;
            2'b10:   next_addr = (a & ~mask) | (inc & mask);
            default: next_addr = inc;
        endcase
    endfunction

    // run_q keeps both readies low until the first clock after reset release
    assign grant_rd  = run_q && axi_arvalid_i && (!axi_awvalid_i || !last_rd_q);
    assign grant_wr  = run_q && axi_awvalid_i && !grant_rd;
    assign bus_state = (state_q == RD_BUS) || (state_q == WR_BUS);
    assign tmo       = (TIMEOUT != 0) && (tcnt_q == TO_VAL) && !wb_ack_i;
    assign bus_done  = bus_state && (wb_ack_i || tmo);
    assign is_last   = (beat_q == len_q);
    assign addr_nxt  = next_addr(wb_addr_q, len_q, burst_q);

    assign wb_addr_o   = wb_addr_q;
    assign wb_data_o   = wb_data_q;
    assign wb_wstrb_o  = wb_wstrb_q;
    assign axi_rdata_o = rdata_q;
    assign axi_rresp_o = rresp_q;
    assign axi_rid_o   = id_q;
    assign axi_bid_o   = id_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        axi_arready_o = 1'b0;
        axi_awready_o = 1'b0;
        axi_wready_o  = 1'b0;
        axi_rvalid_o  = 1'b0;
        axi_rlast_o   = 1'b0;
        axi_bvalid_o  = 1'b0;
        axi_bresp_o   = OKAY;
        wb_cyc_o      = 1'b0;
        wb_stb_o      = 1'b0;
        wb_we_o       = 1'b0;
        case (state_q)
            IDLE: begin
                axi_arready_o = grant_rd;
                axi_awready_o = grant_wr;
                if (grant_rd)      state_d = RD_BUS;
                else if (grant_wr) state_d = WR_DATA;
            end
            RD_BUS: begin
                wb_cyc_o = 1'b1;
                wb_stb_o = 1'b1;
                if (bus_done) state_d = RD_RESP;
            end
            RD_RESP: begin
                wb_cyc_o     = 1'b1;
                axi_rvalid_o = 1'b1;
                axi_rlast_o  = is_last;
                if (axi_rready_i) state_d = is_last ? IDLE : RD_BUS;
            end
            WR_DATA: begin
                wb_cyc_o     = 1'b1;
                axi_wready_o = 1'b1;
                if (axi_wvalid_i) state_d = WR_BUS;
            end
            WR_BUS: begin
                wb_cyc_o = 1'b1;
                wb_stb_o = 1'b1;
                wb_we_o  = 1'b1;
                if (bus_done) state_d = is_last ? WR_RESP : WR_DATA;
            end
            WR_RESP: begin
                axi_bvalid_o = 1'b1;
                axi_bresp_o  = err_q ? SLVERR : OKAY;
                if (axi_bready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q      <= 1'b0;
            last_rd_q  <= 1'b0;
            id_q       <= '0;
            len_q      <= '0;
            beat_q     <= '0;
            burst_q    <= '0;
            err_q      <= 1'b0;
            tcnt_q     <= '0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            wb_wstrb_q <= '0;
            rdata_q    <= '0;
            rresp_q    <= OKAY;
        end else begin
            run_q <= 1'b1;
            if (bus_state && !bus_done) tcnt_q <= tcnt_q + TW'(1);
            else                        tcnt_q <= '0;
            case (state_q)
                IDLE: begin
                    if (grant_rd) begin
                        wb_addr_q  <= axi_araddr_i;
                        id_q       <= axi_arid_i;
                        len_q      <= axi_arlen_i;
                        burst_q    <= axi_arburst_i;
                        beat_q     <= '0;
                        wb_wstrb_q <= '1;
                        last_rd_q  <= 1'b1;
                    end else if (grant_wr) begin
                        wb_addr_q <= axi_awaddr_i;
                        id_q      <= axi_awid_i;
                        len_q     <= axi_awlen_i;
                        burst_q   <= axi_awburst_i;
                        beat_q    <= '0;
                        err_q     <= 1'b0;
                        last_rd_q <= 1'b0;
                    end
                end
                RD_BUS: begin
                    if (bus_done) begin
                        rdata_q <= wb_ack_i ? wb_data_i : '0;
                        rresp_q <= wb_ack_i ? OKAY : SLVERR;
                    end
                end
                RD_RESP: begin
                    if (axi_rready_i && !is_last) begin
                        beat_q    <= beat_q + 8'd1;
                        wb_addr_q <= addr_nxt;
                    end
                end
                WR_DATA: begin
                    if (axi_wvalid_i) begin
                        wb_data_q  <= axi_wdata_i;
                        wb_wstrb_q <= axi_wstrb_i;
                        if (axi_wlast_i != is_last) err_q <= 1'b1;
                    end
                end
                WR_BUS: begin
                    if (bus_done) begin
                        if (tmo) err_q <= 1'b1;
                        if (!is_last) begin
                            beat_q    <= beat_q + 8'd1;
                            wb_addr_q <= addr_nxt;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
